jedro_1_uart_tx_mmio: RTL and testbench
=======================================

Name: jedro_1_uart_tx_mmio

Overview:
Memory-mapped UART transmitter that acts as a SLAVE on the core's data-memory bus, decoded alongside the data RAM. The core's stores fill an 8-entry TX FIFO. An 8N1 serialiser drains the FIFO onto tx_o. The core's loads return status, so firmware in the test programs can print and poll.

Parameters:
DATA_WIDTH, 32, bus data width
ADDR_WIDTH, 32, bus address width
BASE_ADDR, 32'h1000_0000, peripheral base; decode on addr[ADDR_WIDTH-1:4]
FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2
DEFAULT_BAUD_DIV, 16, reset value of BAUDDIV (clock cycles per bit)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
en_i  in  1  bus access strobe
addr_i  in  ADDR_WIDTH  byte address
we_i  in  4  byte write enables; 0 means read
wdata_i  in  DATA_WIDTH  write data
rdata_o  out  DATA_WIDTH  read data, registered
tx_o  out  1  serial output, idles high
irq_o  out  1  level IRQ: TX drained

Behaviour:
- Selected access: en_i=1 and addr_i[31:4]==BASE_ADDR[31:4]. Register index is addr_i[3:2]. All other accesses are ignored.
- Register map:
  - 0 TXDATA, W. If we_i[0], push wdata_i[7:0]. Reads return 0.
  - 1 STATUS, R/W1C:
    - [0] busy (FSM not IDLE)
    - [1] fifo_empty
    - [2] fifo_full
    - [3] overflow, sticky; writing 1 to bit 3 with we_i[0] clears it
    - [4] irq_en, RW
    - [11:8] count
    - all other bits 0
  - 2 BAUDDIV, RW [15:0], byte-lane writes. Written value 0 is stored as 1.
  - 3 reserved: reads 0, writes ignored.
- Read latency: rdata_o updates on the clock edge after a selected read (we_i==0). It holds its value otherwise.
- Reset values: rdata_o=0, tx_o=1, irq_o=0, FIFO empty, overflow=0, irq_en=0, BAUDDIV=DEFAULT_BAUD_DIV, FSM=IDLE.
- Reset mid-frame: tx_o goes to 1 asynchronously and the FIFO is discarded.
- FIFO push rules:
  - Push while full is dropped and sets overflow.
  - Push and pop in the same cycle while full: the push is accepted and count is unchanged.
  - Push and pop in the same cycle while empty cannot happen, since pop requires non-empty.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, at the edge pop into shift register sr[7:0], latch BAUDDIV into bit_div, clear the bit counter, go to START.
  - START: tx_o=0 for bit_div cycles, then go to DATA.
  - DATA: tx_o=sr[0], LSB first. Shift each bit_div cycles. After 8 bits go to STOP.
  - STOP: tx_o=1 for bit_div cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames). Otherwise go to IDLE.
- Frame length: exactly 10*bit_div cycles. The first start bit appears on the cycle after the pop edge.
- BAUDDIV writes mid-frame affect the next frame only.
- Baud counter: counts bit_div-1 down to 0. The bit boundary is at 0.
- irq_o = irq_en & fifo_empty & ~busy, registered, with 1-cycle latency.
- Bus accesses never stall; no ready/wait signal.

Decomposition:
- jedro_1_uart_pkg holds:
  - register index localparams: REG_TXDATA=0, REG_STATUS=1, REG_BAUDDIV=2
  - STATUS bit positions
  - FSM state enum uart_tx_state_e {IDLE, START, DATA, STOP}
- Sub-module jedro_1_sync_fifo is instantiated for the TX FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Reusable later for an RX block.
- The top block contains bus decode, registers, baud counter and FSM.

Test Plan:
- Reset, then read STATUS at BASE+4 → rdata_o=32'h0000_0002 one cycle later; tx_o=1; BAUDDIV reads 16.
- BAUDDIV=4, write 8'hA5 to TXDATA → tx_o sequence per 4 cycles: 0,1,0,1,0,0,1,0,1,1; 40 cycles total; busy=0 afterwards.
- BAUDDIV=2, write 3 bytes on consecutive cycles → 60 contiguous cycles with no idle high between frames; count reads 2,1,0 at successive frame starts.
- Write 10 bytes back-to-back while busy → 9 accepted (1 popped plus 8 queued), 1 dropped, overflow=1. Write STATUS with 32'h8 → overflow=0.
- Write BAUDDIV=0 → reads back 1; a byte transmits in 10 cycles. Write BAUDDIV=8 mid-frame → current frame keeps old period, next frame uses 8.
- irq_en=1, send 1 byte → irq_o=0 during frame, 1 one cycle after the FSM returns to IDLE. Assert rstn_i mid-DATA → tx_o=1 immediately, STATUS reads 32'h2 after release.

Source files
------------

// File: rtl/jedro_1_uart_pkg.sv
// Shared definitions for the jedro_1 UART blocks: register indices, STATUS
// bit positions and the transmitter state encoding.
package jedro_1_uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int ST_BUSY      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_IRQ_EN    = 4;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e;

endpackage

// File: rtl/jedro_1_sync_fifo.sv
// Single-clock FIFO with show-ahead output; a push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module jedro_1_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jedro_1_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, TXDATA/STATUS/BAUDDIV
// registers, TX FIFO, baud down-counter and the serialiser FSM.
module jedro_1_uart_tx_mmio
  import jedro_1_uart_pkg::*;
#(
  parameter int                    DATA_WIDTH       = 32,
  parameter int                    ADDR_WIDTH       = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = 32'h1000_0000,
  parameter int                    FIFO_DEPTH       = 8,
  parameter logic [15:0]           DEFAULT_BAUD_DIV = 16'd16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            we_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  tx_o,
  output logic                  irq_o
);

  logic        sel, wr_txdata, wr_status, wr_baud, rd;
  logic [1:0]  idx;
  logic        overflow, irq_en, busy;
  logic [15:0] baud_div, baud_new;
  logic [DATA_WIDTH-1:0] status;

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  uart_tx_state_e state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d, bit_div_q, bit_div_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic        start_frame;

  logic unused_bits;
  assign unused_bits = ^{wdata_i[DATA_WIDTH-1:16], addr_i[1:0]};

  assign sel       = en_i && (addr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign idx       = addr_i[3:2];
  assign wr_txdata = sel && (idx == REG_TXDATA) && we_i[0];
  assign wr_status = sel && (idx == REG_STATUS) && we_i[0];
  assign wr_baud   = sel && (idx == REG_BAUDDIV) && (we_i[1:0] != 2'b00);
  assign rd        = sel && (we_i == 4'b0000);
  assign busy      = (state_q != IDLE);

  assign baud_new = {we_i[1] ? wdata_i[15:8] : baud_div[15:8],
                     we_i[0] ? wdata_i[7:0]  : baud_div[7:0]};

  jedro_1_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (wr_txdata),
    .pop    (fifo_pop),
    .din    (wdata_i[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    status                      = '0;
    status[ST_BUSY]             = busy;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_FULL]             = fifo_full;
    status[ST_OVERFLOW]         = overflow;
    status[ST_IRQ_EN]           = irq_en;
    status[ST_COUNT_LSB +: 4]   = 4'(fifo_count);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata_o  <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      baud_div <= DEFAULT_BAUD_DIV;
      irq_o    <= 1'b0;
    end else begin
      if (wr_txdata && fifo_full && !fifo_pop) overflow <= 1'b1;
      else if (wr_status && wdata_i[ST_OVERFLOW]) overflow <= 1'b0;
      if (wr_status) irq_en <= wdata_i[ST_IRQ_EN];
      // A zero divider would stall the baud counter, so it is stored as 1.
      if (wr_baud) baud_div <= (baud_new == 16'd0) ? 16'd1 : baud_new;
      if (rd) begin
        case (idx)
          REG_STATUS:  rdata_o <= status;
          REG_BAUDDIV: rdata_o <= DATA_WIDTH'(baud_div);
          default:     rdata_o <= '0;
        endcase
      end
      irq_o <= irq_en & fifo_empty & ~busy;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_div_q  <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_div_q  <= bit_div_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_div_d   = bit_div_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    start_frame = 1'b0;
    tx_o        = 1'b1;
    case (state_q)
      IDLE: start_frame = !fifo_empty;
      START: begin
        tx_o = 1'b0;
        if (baud_cnt_q == 16'd0) begin
          baud_cnt_d = bit_div_q - 16'd1;
          state_d    = DATA;
        end else baud_cnt_d = baud_cnt_q - 16'd1;
      end
      DATA: begin
        tx_o = sr_q[0];
        if (baud_cnt_q == 16'd0) begin
          baud_cnt_d = bit_div_q - 16'd1;
          sr_d       = {1'b0, sr_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else baud_cnt_d = baud_cnt_q - 16'd1;
      end
      STOP: begin
        if (baud_cnt_q == 16'd0) begin
          if (!fifo_empty) start_frame = 1'b1;
          else state_d = IDLE;
        end else baud_cnt_d = baud_cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
    // The divider is sampled only here, so BAUDDIV writes land on the next frame.
    if (start_frame) begin
      sr_d       = fifo_dout;
      bit_div_d  = baud_div;
      baud_cnt_d = baud_div - 16'd1;
      bit_cnt_d  = 3'd0;
      state_d    = START;
    end
  end

  assign fifo_pop = start_frame;

endmodule

// File: tb/tb_jedro_1_uart_tx_mmio.sv
// Bench for jedro_1_uart_tx_mmio: register table, directed frame/irq/reset
// sequences and randomized bursts checked against an abstract UART receiver.
module tb_jedro_1_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_BD = BASE + 32'h8;
  localparam logic [31:0] A_RS = BASE + 32'hC;

  logic        clk = 1'b0, rstn = 1'b0, en = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  we = '0;
  logic [31:0] rdata;
  logic        tx, irq;
  int          total = 0, bad = 0, cyc = 0;

  logic [7:0]  rb [10];
  int          rs [10];
  bit          rok[10];
  logic [7:0]  sent[10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jedro_1_uart_tx_mmio dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .rdata_o(rdata), .tx_o(tx), .irq_o(irq)
  );

  typedef struct {
    logic [31:0] waddr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] st_val(bit busy, bit empty, bit full, bit ovf, bit ie, int cnt);
    logic [3:0] c;
    c = 4'(cnt);
    return {20'b0, c, 3'b0, ie, ovf, full, empty, busy};
  endfunction

  // Called right after a negedge; returns on the next negedge.
  task automatic bus_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    en = 1'b1; addr = a; we = w; wdata = d;
    @(negedge clk);
    en = 1'b0; we = 4'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    en = 1'b1; addr = a; we = 4'b0;
    @(posedge clk);
    #1 d = rdata;
    @(negedge clk);
    en = 1'b0;
  endtask

  // Receives one 8N1 frame sampled at negedges; every cycle of each bit slot
  // must hold the same level, start low and stop high.
  task automatic rx_frame(input int div, output logic [7:0] b, output int st, output bit ok);
    int t;
    logic bitv;
    t = 0; ok = 1'b1; b = '0; st = -1; bitv = 1'b1;
    do begin @(negedge clk); t++; end while (tx !== 1'b0 && t < 400);
    if (tx !== 1'b0) begin ok = 1'b0; return; end
    st = cyc;
    for (int k = 0; k < 10*div; k++) begin
      if (k > 0) @(negedge clk);
      if (k % div == 0) bitv = tx;
      else if (tx !== bitv) ok = 1'b0;
      if (k/div == 0 && tx !== 1'b0) ok = 1'b0;
      if (k/div == 9 && tx !== 1'b1) ok = 1'b0;
      if (k/div >= 1 && k/div <= 8 && k % div == 0) b[k/div-1] = tx;
    end
  endtask

  task automatic rx_many(input int n, input int div);
    for (int k = 0; k < n; k++) rx_frame(div, rb[k], rs[k], rok[k]);
  endtask

  task automatic chk_frames(input string tag, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_ok%0d", tag, k), 32'(rok[k]), 32'd1);
      chk($sformatf("%s_byte%0d", tag, k), 32'(rb[k]), 32'(sent[k]));
      chk($sformatf("%s_start%0d", tag, k), rs[k] - rs[0], k*gap);
    end
  endtask

  initial begin
    logic [31:0] r;
    int c0, div, n, acc, lows;

    vt[0]  = '{32'h0, 4'h0, 32'h0,        A_ST,  32'h2,    "rst_status"};
    vt[1]  = '{32'h0, 4'h0, 32'h0,        A_BD,  32'd16,   "rst_baud"};
    vt[2]  = '{32'h0, 4'h0, 32'h0,        A_TX,  32'h0,    "txdata_reads_0"};
    vt[3]  = '{A_BD,  4'h3, 32'h1234,     A_BD,  32'h1234, "bd_write"};
    vt[4]  = '{32'h0, 4'h0, 32'h0,        A_RS,  32'h0,    "reserved_reads_0"};
    vt[5]  = '{A_BD,  4'h2, 32'hFFFF_AB00, A_BD, 32'hAB34, "bd_lane1"};
    vt[6]  = '{A_BD,  4'h1, 32'h0000_00CD, A_BD, 32'hABCD, "bd_lane0"};
    vt[7]  = '{A_BD,  4'hC, 32'hFFFF_FFFF, A_BD, 32'hABCD, "bd_upper_ignored"};
    vt[8]  = '{BASE+32'h18, 4'h3, 32'h55, A_BD,  32'hABCD, "wrong_base_write"};
    vt[9]  = '{A_BD,  4'h3, 32'h0,        A_BD,  32'h1,    "bd_zero_as_one"};
    vt[10] = '{32'h0, 4'h0, 32'h0, BASE+32'h24,  32'h1,    "unselected_read_holds"};
    vt[11] = '{A_ST,  4'h1, 32'h10,       A_ST,  32'h12,   "irq_en_set"};
    vt[12] = '{A_ST,  4'h2, 32'h0,        A_ST,  32'h12,   "status_lane1_ignored"};
    vt[13] = '{A_ST,  4'h1, 32'h0,        A_ST,  32'h2,    "irq_en_clear"};
    vt[14] = '{A_RS,  4'hF, 32'hFFFF_FFFF, A_RS, 32'h0,    "reserved_write_ignored"};

    repeat (3) @(negedge clk);
    rstn = 1'b1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", rdata, 32'h0);

    for (int i = 0; i < 15; i++) begin
      if (vt[i].we != 4'h0) bus_write(vt[i].waddr, vt[i].we, vt[i].wdata);
      bus_read(vt[i].raddr, r);
      chk(vt[i].name, r, vt[i].exp);
    end

    // Single frame 0xA5 at divider 4, start bit on the cycle after the pop.
    bus_write(A_BD, 4'h3, 32'd4);
    sent[0] = 8'hA5;
    c0 = cyc;
    fork
      bus_write(A_TX, 4'h1, 32'hA5);
      rx_many(1, 4);
    join
    chk_frames("a5", 1, 40);
    chk("a5_latency", rs[0] - c0, 32'd2);
    @(negedge clk);
    chk("a5_tx_idle", 32'(tx), 32'd1);
    bus_read(A_ST, r);
    chk("a5_not_busy", r, st_val(0, 1, 0, 0, 0, 0));

    // Three back-to-back frames at divider 2 with count sampled per frame.
    bus_write(A_BD, 4'h3, 32'd2);
    sent[0] = 8'h11; sent[1] = 8'h80; sent[2] = 8'hFE;
    fork
      begin
        for (int i = 0; i < 3; i++) bus_write(A_TX, 4'h1, 32'(sent[i]));
        bus_read(A_ST, r); chk("b2b_count2", r, st_val(1, 0, 0, 0, 0, 2));
        repeat (19) @(negedge clk);
        bus_read(A_ST, r); chk("b2b_count1", r, st_val(1, 0, 0, 0, 0, 1));
        repeat (19) @(negedge clk);
        bus_read(A_ST, r); chk("b2b_count0", r, st_val(1, 1, 0, 0, 0, 0));
      end
      rx_many(3, 2);
    join
    chk_frames("b2b", 3, 20);
    @(negedge clk);
    bus_read(A_ST, r);
    chk("b2b_done", r, st_val(0, 1, 0, 0, 0, 0));

    // Ten pushes in a row: one popped, eight queued, the tenth dropped.
    for (int i = 0; i < 10; i++) sent[i] = 8'(i*37 + 5);
    fork
      begin
        for (int i = 0; i < 10; i++) bus_write(A_TX, 4'h1, 32'(sent[i]));
        bus_read(A_ST, r); chk("ovf_full", r, st_val(1, 0, 1, 1, 0, 8));
      end
      rx_many(9, 2);
    join
    chk_frames("ovf", 9, 20);
    @(negedge clk);
    bus_read(A_ST, r);  chk("ovf_sticky", r, st_val(0, 1, 0, 1, 0, 0));
    bus_write(A_ST, 4'h1, 32'h8);
    bus_read(A_ST, r);  chk("ovf_cleared", r, st_val(0, 1, 0, 0, 0, 0));

    // Divider 0 behaves as 1: a 10-cycle frame.
    bus_write(A_BD, 4'h3, 32'd0);
    sent[0] = 8'h3C;
    fork
      bus_write(A_TX, 4'h1, 32'h3C);
      rx_many(1, 1);
    join
    chk_frames("div1", 1, 10);
    @(negedge clk);

    // BAUDDIV change during a frame takes effect on the following frame.
    bus_write(A_BD, 4'h3, 32'd4);
    sent[0] = 8'h96; sent[1] = 8'h69;
    fork
      begin
        bus_write(A_TX, 4'h1, 32'h96);
        bus_write(A_TX, 4'h1, 32'h69);
        repeat (3) @(negedge clk);
        bus_write(A_BD, 4'h3, 32'd8);
      end
      begin
        rx_frame(4, rb[0], rs[0], rok[0]);
        rx_frame(8, rb[1], rs[1], rok[1]);
      end
    join
    chk_frames("baudchg", 2, 40);
    @(negedge clk);
    bus_read(A_BD, r);
    chk("baudchg_reg", r, 32'd8);

    // Drained IRQ: low while transmitting, high one cycle after IDLE.
    bus_write(A_ST, 4'h1, 32'h10);
    bus_write(A_BD, 4'h3, 32'd2);
    chk("irq_idle", 32'(irq), 32'd1);
    sent[0] = 8'h5A;
    fork
      begin
        bus_write(A_TX, 4'h1, 32'h5A);
        repeat (5) @(negedge clk);
        chk("irq_mid_frame", 32'(irq), 32'd0);
      end
      rx_many(1, 2);
    join
    chk_frames("irq", 1, 20);
    chk("irq_in_stop", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_latency", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_drained", 32'(irq), 32'd1);

    // Reset in the middle of DATA with a byte still queued.
    bus_write(A_BD, 4'h3, 32'd4);
    bus_write(A_TX, 4'h1, 32'h00);
    bus_write(A_TX, 4'h1, 32'hFF);
    repeat (8) @(negedge clk);
    chk("pre_reset_low", 32'(tx), 32'd0);
    #2 rstn = 1'b0;
    #1 chk("async_reset_tx", 32'(tx), 32'd1);
    chk("async_reset_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    lows = 0;
    repeat (30) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    chk("fifo_discarded", lows, 32'd0);
    bus_read(A_ST, r);  chk("post_reset_status", r, 32'h2);
    bus_read(A_BD, r);  chk("post_reset_baud", r, 32'd16);

    // Random bursts: consecutive pushes from idle, at most nine survive.
    for (int it = 0; it < 6; it++) begin
      div = int'($urandom_range(1, 4));
      n   = int'($urandom_range(1, 10));
      acc = (n < 9) ? n : 9;
      for (int i = 0; i < 10; i++) sent[i] = 8'($urandom);
      bus_write(A_ST, 4'h1, 32'h8);
      bus_write(A_BD, 4'h3, 32'(div));
      fork
        for (int i = 0; i < n; i++) bus_write(A_TX, 4'h1, 32'(sent[i]));
        rx_many(acc, div);
      join
      chk_frames($sformatf("rnd%0d", it), acc, 10*div);
      @(negedge clk);
      bus_read(A_ST, r);
      chk($sformatf("rnd%0d_status", it), r, st_val(0, 1, 0, n > 9, 0, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
